// File: rtl/write_buffer_pkg.sv
// Shared types and constants for the single-entry write-back victim buffer.
package write_buffer_pkg;

  localparam int WORD_W        = 16;
  localparam int LINE_OFFSET_W = 4;
  localparam int LINE_W        = 128;

  typedef logic [WORD_W-1:0]               lc3b_word;
  typedef logic [LINE_W-1:0]               lc3b_8word;
  typedef logic [WORD_W-LINE_OFFSET_W-1:0] lc3b_line_tag;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    DRAIN,
    RESP
  } write_buffer_state_t;

endpackage

// File: rtl/write_buffer_entry.sv
// Storage for the buffered dirty line: valid bit, tag and data, with a tag-match output.
module write_buffer_entry
  import write_buffer_pkg::*;
#(
  parameter int TAG_W = WORD_W - LINE_OFFSET_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [TAG_W-1:0] load_tag,
  input  lc3b_8word        load_data,
  input  logic [TAG_W-1:0] cmp_tag,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output lc3b_8word        data,
  output logic             hit
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  lc3b_8word        data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      tag_d   = load_tag;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;
  assign hit   = valid_q && (tag_q == cmp_tag);

endmodule

// File: rtl/write_buffer.sv
// Single-entry write-back victim buffer between the L1 arbiter and memory.
// Build option: WRITE_BUFFER_HIT_FWD_EN serves reads that match the buffer directly from it.
//
// state    | meaning
// IDLE     | evaluate arbiter request or start a background drain
// MEM_READ | line read outstanding on memory port
// DRAIN    | buffered line being written back to memory
// RESP     | one-cycle completion pulse to the arbiter
module write_buffer
  import write_buffer_pkg::*;
#(
  parameter int ADDR_W   = WORD_W,
  parameter int OFFSET_W = LINE_OFFSET_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arb_read,
  input  logic              arb_write,
  input  logic [ADDR_W-1:0] arb_address,
  input  lc3b_8word         arb_wdata,
  output lc3b_8word         arb_rdata,
  output logic              arb_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output lc3b_8word         pmem_wdata,
  input  lc3b_8word         pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W = ADDR_W - OFFSET_W;

  write_buffer_state_t state_q, state_d;

  logic [TAG_W-1:0]  req_tag, buf_tag;
  logic              buf_valid, buf_hit, buf_load, buf_clear;
  lc3b_8word         buf_data;
  lc3b_8word         rdata_q, rdata_d;
  lc3b_8word         pmem_wdata_q, pmem_wdata_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic              unused_offset_bits;

  assign req_tag            = arb_address[ADDR_W-1:OFFSET_W];
  assign unused_offset_bits = ^arb_address[OFFSET_W-1:0];

  write_buffer_entry #(
    .TAG_W(TAG_W)
  ) u_entry (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .load_tag (req_tag),
    .load_data(arb_wdata),
    .cmp_tag  (req_tag),
    .valid    (buf_valid),
    .tag      (buf_tag),
    .data     (buf_data),
    .hit      (buf_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rdata_q        <= '0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      rdata_q        <= rdata_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
    end
  end

  // A read is checked first, so a simultaneous write is silently dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_read) begin
`ifdef WRITE_BUFFER_HIT_FWD_EN
          state_d = buf_hit ? RESP : MEM_READ;
`else
          state_d = buf_hit ? DRAIN : MEM_READ;
`endif
        end else if (arb_write) begin
          state_d = (!buf_valid || buf_hit) ? RESP : DRAIN;
        end else if (buf_valid) begin
          state_d = DRAIN;
        end
      end
      MEM_READ: if (pmem_resp) state_d = RESP;
      DRAIN:    if (pmem_resp) state_d = IDLE;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata_d        = rdata_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    case (state_q)
      IDLE: begin
        if (arb_read) begin
`ifdef WRITE_BUFFER_HIT_FWD_EN
          if (buf_hit) rdata_d = buf_data;
`endif
        end else if (arb_write && (!buf_valid || buf_hit)) begin
          buf_load = 1'b1;
        end
      end
      MEM_READ: if (pmem_resp) rdata_d = pmem_rdata;
      DRAIN:    if (pmem_resp) buf_clear = 1'b1;
      default:  ;
    endcase
    // Memory-side address/data are registered on entry so the port is glitch-free.
    case (state_d)
      MEM_READ: pmem_address_d = {req_tag, {OFFSET_W{1'b0}}};
      DRAIN: begin
        pmem_address_d = {buf_tag, {OFFSET_W{1'b0}}};
        pmem_wdata_d   = buf_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    arb_resp   = (state_q == RESP);
    pmem_read  = (state_q == MEM_READ);
    pmem_write = (state_q == DRAIN);
  end

  assign arb_rdata    = rdata_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;

endmodule
